// File: rtl/adler32_par.sv
// adler32_par: pipelined Adler-32 engine, BYTE_NUM bytes per beat, MSB byte first.
// Latency: two register stages; val_o/dat_o follow an accepted beat by 2 clocks, one result per beat.
// Backpressure: none; a beat can be accepted every cycle and the producer only paces frames.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start_i       begin a new checksum (loads the seed); may coincide with the first beat
//   val_i/dat_i   input beat; byte 0 is dat_i[DATA_WD-1 -: 8]
//   num_i         valid bytes minus one, counted from the top byte down
//   lst_i         marks the last beat of the frame
//   seed_i        {B,A} start value, only when ADLER32_SEED_EN is defined
//   busy_o        frame open or a beat still in the pipeline
//   val_o/dat_o   running checksum {B,A} after each accepted beat
//   done_o        with val_o on the result of the lst_i beat
//
// Build option: define ADLER32_SEED_EN to add seed_i; otherwise start_i loads A=1, B=0.

module adler32_par #(
  parameter int BYTE_NUM = 4,
  parameter int DATA_WD  = 8 * BYTE_NUM,
  parameter int NUM_WD   = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic [NUM_WD-1:0]  num_i,
  input  logic               lst_i,
`ifdef ADLER32_SEED_EN
  input  logic [31:0]        seed_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic               val_o,
  output logic [31:0]        dat_o
);

  localparam logic [16:0] MOD   = 17'd65521;
  localparam int          N_WD  = 5;   // holds n up to 16
  localparam int          S1_WD = 12;  // 16 * 255 < 2^12
  localparam int          S2_WD = 16;  // 255 * (16*17/2) < 2^16
  localparam int          W_WD  = 21;  // stage-2 wide sums stay below 2^21

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_acc;
  logic   w_drop;

  // Stage 1 signals
  logic [N_WD-1:0]  w_n;
  logic [S1_WD-1:0] w_s1;
  logic [S2_WD-1:0] w_s2;
  logic             r_s1_vld;
  logic             r_s1_lst;
  logic [N_WD-1:0]  r_s1_n;
  logic [S1_WD-1:0] r_s1_sum;
  logic [S2_WD-1:0] r_s2_sum;

  // Seed and stage 2 signals
  logic [15:0]      w_seed_a;
  logic [15:0]      w_seed_b;
  logic [15:0]      r_seed_a;
  logic [15:0]      r_seed_b;
  logic             r_use_seed;
  logic             w_go;
  logic [15:0]      w_base_a;
  logic [15:0]      w_base_b;
  logic [W_WD-1:0]  w_wa;
  logic [W_WD-1:0]  w_wb;
  logic [15:0]      w_na;
  logic [15:0]      w_nb;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic             r_val;
  logic             r_done;

  // 2^16 = 15 (mod 65521): one hi*15+lo fold brings any value < 2^21 below 2^17,
  // after which at most two subtracts give the canonical residue.
  function automatic logic [15:0] mod_reduce(input logic [W_WD-1:0] x);
    logic [16:0] r;
    if (x[W_WD-1:17] != '0) begin
      r = 17'(x[W_WD-1:16]) * 17'd15 + 17'(x[15:0]);
    end else begin
      r = x[16:0];
    end
    if (r >= MOD) r = r - MOD;
    if (r >= MOD) r = r - MOD;
    return 16'(r);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A beat is only taken in IDLE when it arrives together with start_i.
        w_acc = val_i & start_i;
        if (start_i) begin
          w_state_nxt = (val_i & lst_i) ? ST_IDLE : ST_RUN;
        end
      end
      ST_RUN: begin
        w_acc  = val_i;
        // Restart inside a frame discards the beat sitting in stage 1.
        w_drop = start_i;
        if (val_i & lst_i) begin
          w_state_nxt = ST_IDLE;
        end else if (start_i) begin
          w_state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------- stage 1
  // S1 = sum of used bytes, S2 = sum of (n-i)*d_i; byte i is weighted by
  // how many times it is folded into B within the beat.
  always_comb begin
    w_n = N_WD'(num_i) + N_WD'(1);
    if (w_n > N_WD'(BYTE_NUM)) w_n = N_WD'(BYTE_NUM);
    w_s1 = '0;
    w_s2 = '0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (N_WD'(i) < w_n) begin
        w_s1 = w_s1 + S1_WD'(dat_i[DATA_WD-1-8*i -: 8]);
        w_s2 = w_s2 + S2_WD'(w_n - N_WD'(i)) * S2_WD'(dat_i[DATA_WD-1-8*i -: 8]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_lst <= 1'b0;
      r_s1_n   <= '0;
      r_s1_sum <= '0;
      r_s2_sum <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_lst <= lst_i;
        r_s1_n   <= w_n;
        r_s1_sum <= w_s1;
        r_s2_sum <= w_s2;
      end
    end
  end

  // ---------------------------------------------------------------- seed
`ifdef ADLER32_SEED_EN
  assign w_seed_a = (seed_i[15:0]  >= 16'd65521) ? seed_i[15:0]  - 16'd65521 : seed_i[15:0];
  assign w_seed_b = (seed_i[31:16] >= 16'd65521) ? seed_i[31:16] - 16'd65521 : seed_i[31:16];
`else
  assign w_seed_a = 16'd1;
  assign w_seed_b = 16'd0;
`endif

  // ---------------------------------------------------------------- stage 2
  // The seed is held aside and picked up by the first beat of the frame, so
  // dat_o keeps the previous result until a new beat completes.
  assign w_go     = r_s1_vld & ~w_drop;
  assign w_base_a = r_use_seed ? r_seed_a : r_a;
  assign w_base_b = r_use_seed ? r_seed_b : r_b;
  // r_a/r_b feed straight back, so consecutive beats chain without a bubble.
  assign w_wa     = W_WD'(w_base_a) + W_WD'(r_s1_sum);
  assign w_wb     = W_WD'(w_base_b) + W_WD'(r_s1_n) * W_WD'(w_base_a) + W_WD'(r_s2_sum);
  assign w_na     = mod_reduce(w_wa);
  assign w_nb     = mod_reduce(w_wb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= 16'd1;
      r_b        <= 16'd0;
      r_val      <= 1'b0;
      r_done     <= 1'b0;
      r_use_seed <= 1'b0;
      r_seed_a   <= 16'd1;
      r_seed_b   <= 16'd0;
    end else begin
      r_val  <= w_go;
      r_done <= w_go & r_s1_lst;
      if (w_go) begin
        r_a <= w_na;
        r_b <= w_nb;
      end
      // start_i wins: a beat of the previous frame leaving stage 1 in the same
      // cycle has already used the old base.
      if (start_i) begin
        r_use_seed <= 1'b1;
        r_seed_a   <= w_seed_a;
        r_seed_b   <= w_seed_b;
      end else if (w_go) begin
        r_use_seed <= 1'b0;
      end
    end
  end

  assign busy_o = (r_state == ST_RUN) | r_s1_vld | r_val;
  assign done_o = r_done;
  assign val_o  = r_val;
  assign dat_o  = {r_b, r_a};

endmodule

// File: tb/tb_adler32_par.sv
module tb_adler32_par;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        val_i;
  logic [31:0] dat_i;
  logic [1:0]  num_i;
  logic        lst_i;
  logic [31:0] seed_v;
  logic        busy_o;
  logic        done_o;
  logic        val_o;
  logic [31:0] dat_o;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ma          = 1;
  int mb          = 0;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic        done;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  adler32_par #(.BYTE_NUM(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .val_i   (val_i),
    .dat_i   (dat_i),
    .num_i   (num_i),
    .lst_i   (lst_i),
`ifdef ADLER32_SEED_EN
    .seed_i  (seed_v),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .val_o   (val_o),
    .dat_o   (dat_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every output pulse is logged with the cycle it appeared in.
  always @(negedge clk) begin
    if (val_o === 1'b1 || done_o === 1'b1) obs_q.push_back('{cyc, dat_o, done_o});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one cycle of inputs. The reference model is plain byte-serial
  // Adler-32; acc says whether this beat is expected to produce a result.
  task automatic send(input logic st, input logic vl, input logic [31:0] d,
                      input int nm, input logic l, input logic acc);
    logic [31:0] dv;
    int          n;
    start_i = st;
    val_i   = vl;
    dat_i   = d;
    num_i   = nm[1:0];
    lst_i   = l;
    if (st) begin
`ifdef ADLER32_SEED_EN
      ma = int'(seed_v[15:0]);
      mb = int'(seed_v[31:16]);
      if (ma >= 65521) ma = ma - 65521;
      if (mb >= 65521) mb = mb - 65521;
`else
      ma = 1;
      mb = 0;
`endif
    end
    if (acc) begin
      dv = d;
      n  = nm + 1;
      for (int i = 0; i < n; i++) begin
        ma = (ma + int'(dv[31-8*i -: 8])) % 65521;
        mb = (mb + ma) % 65521;
      end
      exp_q.push_back('{cyc + 2, {mb[15:0], ma[15:0]}, l});
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    val_i   = 1'b0;
    lst_i   = 1'b0;
    dat_i   = $urandom;
    num_i   = 2'($urandom);
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    start_i = 1'b1;
    val_i   = 1'b1;
    lst_i   = 1'b0;
    dat_i   = $urandom;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (val_o !== 1'b0) begin miscompares++; $display("FAIL reset_val: got %b want 0", val_o); end
    vectors++;
    if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_o); end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    vectors++;
    if (dat_o !== 32'h00000001) begin miscompares++; $display("FAIL reset_dat: got %h want 00000001", dat_o); end
    start_i = 1'b0;
    val_i   = 1'b0;
    rst     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy_o !== 1'b0 || val_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got busy %b val %b want 0 0", busy_o, val_o);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_directed;
    send(1, 1, 32'h04090409, 3, 1, 1);
    vectors++;
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL busy_inflight: got %b want 1", busy_o); end
    @(posedge clk);
    #1;
    vectors++;
    if ({val_o, done_o, busy_o} !== 3'b111) begin
      miscompares++;
      $display("FAIL pulse_flags: got val %b done %b busy %b want 1 1 1", val_o, done_o, busy_o);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({val_o, done_o, busy_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL after_pulse: got val %b done %b busy %b want 0 0 0", val_o, done_o, busy_o);
    end
    send(1, 1, 32'h57696B69, 3, 0, 1);
    send(0, 1, 32'h70656469, 3, 0, 1);
    send(0, 1, 32'h61000000, 0, 1, 1);
    send(0, 0, 32'h0, 0, 0, 0);
    send(1, 1, 32'h01020304, 1, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL directed_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].dat !== exp_q[k].dat || obs_q[k].done !== exp_q[k].done) begin
        miscompares++;
        $display("FAIL directed_beat%0d: got cyc %0d dat %h done %b want cyc %0d dat %h done %b",
                 k, obs_q[k].cyc, obs_q[k].dat, obs_q[k].done, exp_q[k].cyc, exp_q[k].dat, exp_q[k].done);
      end
    end
    vectors++;
    if (obs_q.size() < 5 || obs_q[0].dat !== 32'h0040001b) begin
      miscompares++; $display("FAIL short_frame: got %h want 0040001b", (obs_q.size() > 0) ? obs_q[0].dat : 32'hx);
    end
    vectors++;
    if (obs_q.size() < 5 || obs_q[3].dat !== 32'h11E60398) begin
      miscompares++; $display("FAIL wikipedia: got %h want 11e60398", (obs_q.size() > 3) ? obs_q[3].dat : 32'hx);
    end
    vectors++;
    if (obs_q.size() < 5 || obs_q[4].dat !== 32'h00060004) begin
      miscompares++; $display("FAIL partial_beat: got %h want 00060004", (obs_q.size() > 4) ? obs_q[4].dat : 32'hx);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 256; k++) begin
      send(k == 0, 1, 32'hFFFFFFFF, 3, k == 255, 1);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].dat !== exp_q[k].dat || obs_q[k].done !== exp_q[k].done) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: got cyc %0d dat %h done %b want cyc %0d dat %h done %b",
                 k, obs_q[k].cyc, obs_q[k].dat, obs_q[k].done, exp_q[k].cyc, exp_q[k].dat, exp_q[k].done);
      end
    end
    vectors++;
    if (dat_o !== 32'h79A6FC2E) begin
      miscompares++; $display("FAIL b2b_final: got %h want 79a6fc2e", dat_o);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_restart;
    // Beat in IDLE without start_i must vanish.
    send(0, 1, $urandom, 3, 1, 0);
    // Frame abandoned after one beat, new frame opens with start_i+val_i.
    send(1, 1, 32'h04090409, 3, 0, 1);
    send(0, 0, 32'h0, 0, 0, 0);
    send(0, 0, 32'h0, 0, 0, 0);
    send(1, 1, 32'h04090409, 3, 1, 1);
    send(0, 0, 32'h0, 0, 0, 0);
    // Restart while a beat sits in stage 1: that beat is dropped.
    send(1, 1, $urandom, 3, 0, 1);
    send(0, 1, $urandom, 3, 0, 0);
    send(1, 1, $urandom, 2, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL restart_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].dat !== exp_q[k].dat || obs_q[k].done !== exp_q[k].done) begin
        miscompares++;
        $display("FAIL restart_beat%0d: got cyc %0d dat %h done %b want cyc %0d dat %h done %b",
                 k, obs_q[k].cyc, obs_q[k].dat, obs_q[k].done, exp_q[k].cyc, exp_q[k].dat, exp_q[k].done);
      end
    end
    vectors++;
    if (obs_q.size() < 2 || obs_q[1].dat !== 32'h0040001b) begin
      miscompares++; $display("FAIL restart_same_cycle: got %h want 0040001b", (obs_q.size() > 1) ? obs_q[1].dat : 32'hx);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_rst_mid;
    send(1, 1, $urandom | 32'h01000000, 3, 0, 1);
    send(0, 0, 32'h0, 0, 0, 0);
    send(0, 1, $urandom, 3, 0, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if ({val_o, done_o, busy_o} !== 3'b000 || dat_o !== 32'h00000001) begin
      miscompares++;
      $display("FAIL rst_mid: got val %b done %b busy %b dat %h want 0 0 0 00000001", val_o, done_o, busy_o, dat_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, 1, $urandom, 3, 1, 0);
    send(1, 1, $urandom, 3, 0, 1);
    send(0, 1, $urandom, 1, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rst_mid_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].dat !== exp_q[k].dat || obs_q[k].done !== exp_q[k].done) begin
        miscompares++;
        $display("FAIL rst_mid_beat%0d: got cyc %0d dat %h done %b want cyc %0d dat %h done %b",
                 k, obs_q[k].cyc, obs_q[k].dat, obs_q[k].done, exp_q[k].cyc, exp_q[k].dat, exp_q[k].done);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    int  nb;
    int  gap;
    logic alone;
    for (int f = 0; f < 24; f++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) send(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 3), 1, 0);
      nb    = $urandom_range(1, 8);
      alone = 1'($urandom_range(0, 1));
      if (alone) send(1, 0, $urandom, 0, 0, 0);
      for (int b = 0; b < nb; b++) begin
        if (b > 0) begin
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) send(0, 0, $urandom, 0, 0, 0);
        end
        send((b == 0) && !alone, 1, $urandom, $urandom_range(0, 3), b == nb - 1, 1);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].dat !== exp_q[k].dat || obs_q[k].done !== exp_q[k].done) begin
        miscompares++;
        $display("FAIL random_beat%0d: got cyc %0d dat %h done %b want cyc %0d dat %h done %b",
                 k, obs_q[k].cyc, obs_q[k].dat, obs_q[k].done, exp_q[k].cyc, exp_q[k].dat, exp_q[k].done);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

`ifdef ADLER32_SEED_EN
  task automatic test_seed;
    seed_v = 32'hFFF0FFF0;
    send(1, 1, 32'h00000000, 0, 1, 1);
    seed_v = 32'hFFF50003;
    send(1, 1, $urandom, 3, 0, 1);
    send(0, 1, $urandom, 2, 1, 1);
    seed_v = $urandom;
    send(1, 1, $urandom, 3, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL seed_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].dat !== exp_q[k].dat || obs_q[k].done !== exp_q[k].done) begin
        miscompares++;
        $display("FAIL seed_beat%0d: got cyc %0d dat %h done %b want cyc %0d dat %h done %b",
                 k, obs_q[k].cyc, obs_q[k].dat, obs_q[k].done, exp_q[k].cyc, exp_q[k].dat, exp_q[k].done);
      end
    end
    vectors++;
    if (obs_q.size() < 1 || obs_q[0].dat !== 32'hFFEFFFF0) begin
      miscompares++; $display("FAIL seed_vector: got %h want ffeffff0", (obs_q.size() > 0) ? obs_q[0].dat : 32'hx);
    end
    obs_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    val_i   = 1'b0;
    dat_i   = '0;
    num_i   = '0;
    lst_i   = 1'b0;
    seed_v  = 32'h00000001;
    test_reset;
    test_directed;
    test_back_to_back;
    test_restart;
    test_rst_mid;
    test_random;
`ifdef ADLER32_SEED_EN
    test_seed;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
